// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding-select and MDU scoreboard state types
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, WB = 2'b10} mdu_state_t;
  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_sb_unit_mdu_scoreboard.sv
// mdu_scoreboard: tracks one in-flight MDU op, counts down to write-back, arbitrates the W port
// Ports: clk, reset_n (async active-low); mdu_start/dest from E; regwrite_w (W stage owns the port);
//        mdu_busy, mdu_wb_valid, mdu_wb_reg out; act_valid/act_reg give the dest the stall logic must guard.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mdu_start,
  input  logic [REGW-1:0] dest,
  input  logic            regwrite_w,
  output logic            mdu_busy,
  output logic            mdu_wb_valid,
  output logic [REGW-1:0] mdu_wb_reg,
  output logic            act_valid,
  output logic [REGW-1:0] act_reg
);
  mdu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REGW-1:0] reg_q, reg_d;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reg_d        = reg_q;
    mdu_wb_valid = (state_q == WB) & ~regwrite_w;
    if (state_q == IDLE && mdu_start) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(MDU_LAT - 2);
      reg_d   = dest;
    end else if (state_q == BUSY) begin
      state_d = (cnt_q == '0) ? WB : BUSY;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
    end else if (state_q == WB && mdu_wb_valid) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
    end
  end
  assign mdu_busy   = state_q != IDLE;
  assign mdu_wb_reg = reg_q;
  // the latched dest stays guarded until the cycle its write actually lands
  assign act_valid  = mdu_busy | mdu_start;
  assign act_reg    = mdu_busy ? reg_q : dest;
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset_n) !(mdu_start && mdu_busy));
endmodule

// File: rtl/hazard_sb_unit.sv
// hazard_sb_unit: 5-stage MIPS forwarding/stall unit with a one-op MDU scoreboard
// Ports: clk, reset_n (async active-low); D/E/M/W register ids and control bits in;
//        forwarda/bD, forwarda/bE (00 RF, 01 W, 10 M), forwardM, stallF/stallD/flushE,
//        mdu_busy, mdu_wb_valid, mdu_wb_reg out.
// Macro HAZ_STORE_FWD_EN: W->M store-data bypass, letting a load feed a following store without stalling.
module hazard_sb_unit
  import hazard_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregD,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteD,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            bneD,
  input  logic            mdu_opD,
  input  logic            mdu_startE,
  input  logic            memwriteD,
  input  logic            memwriteM,
  input  logic [REGW-1:0] rtM,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            forwardM,
  output logic            stallF,
  output logic            stallD,
  output logic            flushE,
  output logic            mdu_busy,
  output logic            mdu_wb_valid,
  output logic [REGW-1:0] mdu_wb_reg
);
  logic act_valid, lwstall, brstall, rawstall, wawstall, strstall;
  logic [REGW-1:0] act_reg;
  mdu_scoreboard #(.REGW(REGW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_sb (
    .clk(clk), .reset_n(reset_n), .mdu_start(mdu_startE), .dest(writeregE),
    .regwrite_w(regwriteW), .mdu_busy(mdu_busy), .mdu_wb_valid(mdu_wb_valid),
    .mdu_wb_reg(mdu_wb_reg), .act_valid(act_valid), .act_reg(act_reg)
  );
  assign forwardaD = (rsD != '0) & (rsD == writeregM) & regwriteM;
  assign forwardbD = (rtD != '0) & (rtD == writeregM) & regwriteM;
  assign forwardaE = fwd_pick((rsE != '0) & (rsE == writeregM) & regwriteM,
                              (rsE != '0) & (rsE == writeregW) & regwriteW);
  assign forwardbE = fwd_pick((rtE != '0) & (rtE == writeregM) & regwriteM,
                              (rtE != '0) & (rtE == writeregW) & regwriteW);
`ifdef HAZ_STORE_FWD_EN
  // a load feeding only the store's data operand is bypassed W->M instead of stalled
  assign lwstall  = memtoregE & (rtE != '0) & ((rtE == rsD) | (rtE == rtD))
                  & ~(memwriteD & (rtE == rtD) & (rtE != rsD));
  assign forwardM = memwriteM & (rtM != '0) & (rtM == writeregW) & regwriteW;
`else
  logic unused_store;
  assign unused_store = ^{memwriteD, memwriteM, rtM};
  assign lwstall  = memtoregE & (rtE != '0) & ((rtE == rsD) | (rtE == rtD));
  assign forwardM = 1'b0;
`endif
  assign brstall  = (branchD | bneD)
                  & ((regwriteE & ((writeregE == rsD) | (writeregE == rtD)))
                   | (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
  assign rawstall = act_valid & (act_reg != '0) & ((act_reg == rsD) | (act_reg == rtD));
  assign wawstall = act_valid & regwriteD & (writeregD == act_reg);
  assign strstall = mdu_opD & act_valid;
  assign stallD   = lwstall | brstall | rawstall | wawstall | strstall;
  assign stallF   = stallD;
  assign flushE   = stallD;
endmodule

// File: tb/tb_hazard_sb_unit.sv
// tb_hazard_sb_unit: randomized + directed scoreboard check of hazard_sb_unit against a reference model
module tb_hazard_sb_unit;
  localparam int LAT = 4;
  typedef struct {
    logic reset_n;
    logic [4:0] rsD, rtD, rsE, rtE, wD, wE, wM, wW, rtM;
    logic rwD, rwE, rwM, rwW, mtrE, mtrM, brD, bneD, mduD, mstE, mwD, mwM;
  } stim_t;
  typedef struct {
    logic faD, fbD, fM, sF, sD, fE, busy, wbv;
    logic [1:0] faE, fbE;
    logic [4:0] wbr;
  } exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  stim_t cur, prev;
  exp_t q[$];
  int errors = 0, checks = 0;
  bit m_inflight = 0;
  int m_age = 0;
  logic [4:0] m_reg = 0;
  logic forwardaD, forwardbD, forwardM, stallF, stallD, flushE, mdu_busy, mdu_wb_valid;
  logic [1:0] forwardaE, forwardbE;
  logic [4:0] mdu_wb_reg;
  hazard_sb_unit dut (
    .clk(clk), .reset_n(cur.reset_n), .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE),
    .writeregD(cur.wD), .writeregE(cur.wE), .writeregM(cur.wM), .writeregW(cur.wW),
    .regwriteD(cur.rwD), .regwriteE(cur.rwE), .regwriteM(cur.rwM), .regwriteW(cur.rwW),
    .memtoregE(cur.mtrE), .memtoregM(cur.mtrM), .branchD(cur.brD), .bneD(cur.bneD),
    .mdu_opD(cur.mduD), .mdu_startE(cur.mstE), .memwriteD(cur.mwD), .memwriteM(cur.mwM), .rtM(cur.rtM),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardM(forwardM), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .mdu_busy(mdu_busy), .mdu_wb_valid(mdu_wb_valid), .mdu_wb_reg(mdu_wb_reg)
  );
  function automatic logic [1:0] fsel(input logic [4:0] src, input stim_t s);
    if (src != 0 && src == s.wM && s.rwM) return 2'b10;
    if (src != 0 && src == s.wW && s.rwW) return 2'b01;
    return 2'b00;
  endfunction
  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit has_act, lw, br, raw, waw, str;
    logic [4:0] act;
    has_act = m_inflight || s.mstE;
    act = m_inflight ? m_reg : s.wE;
    e.faD = s.rsD != 0 && s.rsD == s.wM && s.rwM;
    e.fbD = s.rtD != 0 && s.rtD == s.wM && s.rwM;
    e.faE = fsel(s.rsE, s);
    e.fbE = fsel(s.rtE, s);
    lw = s.mtrE && s.rtE != 0 && (s.rtE == s.rsD || s.rtE == s.rtD);
`ifdef HAZ_STORE_FWD_EN
    if (s.mwD && s.rtE == s.rtD && s.rtE != s.rsD) lw = 0;
    e.fM = s.mwM && s.rtM != 0 && s.rtM == s.wW && s.rwW;
`else
    e.fM = 0;
`endif
    br = (s.brD || s.bneD) && ((s.rwE && (s.wE == s.rsD || s.wE == s.rtD)) ||
                               (s.mtrM && (s.wM == s.rsD || s.wM == s.rtD)));
    raw = has_act && act != 0 && (act == s.rsD || act == s.rtD);
    waw = has_act && s.rwD && s.wD == act;
    str = s.mduD && has_act;
    e.sD = lw || br || raw || waw || str;
    e.sF = e.sD;
    e.fE = e.sD;
    e.busy = m_inflight;
    e.wbv = m_inflight && m_age >= LAT && !s.rwW;
    e.wbr = m_reg;
    return e;
  endfunction
  task automatic model_edge(input stim_t s);
    if (!s.reset_n) begin
      m_inflight = 0; m_reg = 0;
    end else if (m_inflight) begin
      if (m_age >= LAT && !s.rwW) m_inflight = 0;
      else m_age++;
    end else if (s.mstE) begin
      m_inflight = 1; m_age = 1; m_reg = s.wE;
    end
  endtask
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    model_edge(prev);
    if (!s.reset_n) begin
      m_inflight = 0; m_reg = 0;
    end
    if (m_inflight) s.mstE = 0;
    cur = s;
    prev = s;
    q.push_back(model(s));
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("fwdD", {forwardaD, forwardbD}, {e.faD, e.fbD});
        chk("fwdE", {forwardaE, forwardbE}, {e.faE, e.fbE});
        chk("fwdM", forwardM, e.fM);
        chk("stall", {stallF, stallD, flushE}, {e.sF, e.sD, e.fE});
        chk("mdu", {mdu_busy, mdu_wb_valid, mdu_wb_reg}, {e.busy, e.wbv, e.wbr});
      end
    end
  end
  function automatic stim_t rnd();
    stim_t s;
    s.reset_n = $urandom_range(0, 99) != 0;
    s.rsD = 5'($urandom_range(0, 7)); s.rtD = 5'($urandom_range(0, 7));
    s.rsE = 5'($urandom_range(0, 7)); s.rtE = 5'($urandom_range(0, 7));
    s.wD = 5'($urandom_range(0, 7)); s.wE = 5'($urandom_range(0, 7));
    s.wM = 5'($urandom_range(0, 7)); s.wW = 5'($urandom_range(0, 7));
    s.rtM = 5'($urandom_range(0, 7));
    s.rwD = 1'($urandom_range(0, 1)); s.rwE = 1'($urandom_range(0, 1));
    s.rwM = 1'($urandom_range(0, 1)); s.rwW = 1'($urandom_range(0, 1));
    s.mtrE = $urandom_range(0, 3) == 0; s.mtrM = $urandom_range(0, 3) == 0;
    s.brD = $urandom_range(0, 3) == 0; s.bneD = $urandom_range(0, 5) == 0;
    s.mduD = $urandom_range(0, 3) == 0; s.mstE = $urandom_range(0, 5) == 0;
    s.mwD = 1'($urandom_range(0, 1)); s.mwM = 1'($urandom_range(0, 1));
    return s;
  endfunction
  initial begin
    stim_t n, s;
    n = '{default: '0};
    cur = n;
    prev = n;
    n.reset_n = 1;
    s = n; s.reset_n = 0; step(s); step(s);
    s = n; s.wM = 3; s.wW = 3; s.rwM = 1; s.rwW = 1; s.rsE = 3; step(s);
    s.rsE = 0; step(s);
    s = n; s.mtrE = 1; s.rtE = 5; s.rsD = 5; step(s);
    step(n);
    s.rtE = 0; step(s);
    s = n; s.mstE = 1; s.wE = 8; s.rsD = 8; step(s);
    s = n; s.rsD = 8;
    for (int i = 0; i < 6; i++) step(s);
    s = n; s.mstE = 1; s.wE = 9; s.rtD = 9; step(s);
    s = n; s.rtD = 9;
    for (int i = 0; i < 3; i++) step(s);
    s.rwW = 1; s.wW = 2; step(s);
    s.rwW = 0; step(s); step(s);
    s = n; s.mstE = 1; s.wE = 10; step(s);
    s = n; s.mduD = 1; step(s);
    s = n; s.reset_n = 0; step(s);
    step(n);
    s = n; s.mtrE = 1; s.rtE = 4; s.mwD = 1; s.rtD = 4; s.rsD = 1; step(s);
    s = n; s.mwM = 1; s.rtM = 4; s.wW = 4; s.rwW = 1; step(s);
    for (int i = 0; i < 3000; i++) step(rnd());
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
